// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: single-beat cache-to-AXI4 bridge with independent read and write FSMs.
// Each accepted cache request becomes one AXI transaction with a single beat (len 0, INCR burst).
// Optional macro BRIDGE_RAW_CHECK_EN: a read is stalled while a write to the same
// 16-byte line is outstanding or is being accepted in the same cycle.
module cache_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // cache read port
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [DATA_WIDTH-1:0]   ret_data,
  // cache write port
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_wstrb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_rdy,
  // AXI AR
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI R
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI AW
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI W
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI B
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wr_state_t;

  rd_state_t                 r_rd_state, w_rd_next;
  wr_state_t                 r_wr_state, w_wr_next;
  logic [ADDR_WIDTH-1:0]     r_rd_addr, r_wr_addr;
  logic [2:0]                r_rd_type, r_wr_type;
  logic [DATA_WIDTH/8-1:0]   r_wr_wstrb;
  logic [DATA_WIDTH-1:0]     r_wr_data;
  logic                      r_aw_done, r_w_done;
  logic                      w_raw_block;
  logic                      w_aw_hs, w_w_hs;
  logic                      w_unused_axi;

  // Transfer-size encoding; reserved type codes fall back to a full line.
  function automatic logic [2:0] f_size(input logic [2:0] t);
    case (t)
      3'b000:  f_size = 3'd0;
      3'b001:  f_size = 3'd1;
      3'b010:  f_size = 3'd2;
      default: f_size = 3'd4;
    endcase
  endfunction

  // IDs, responses and rlast carry no information for a single-beat, single-ID master.
  assign w_unused_axi = ^{rid, rresp, rlast, bid, bresp};

  assign arid    = '0;
  assign arlen   = '0;
  assign arburst = 2'b01;
  assign araddr  = r_rd_addr;
  assign arsize  = f_size(r_rd_type);
  assign awid    = '0;
  assign awlen   = '0;
  assign awburst = 2'b01;
  assign awaddr  = r_wr_addr;
  assign awsize  = f_size(r_wr_type);
  assign wdata   = r_wr_data;
  assign wstrb   = r_wr_wstrb;
  assign wlast   = 1'b1;

`ifdef BRIDGE_RAW_CHECK_EN
  // Read-after-write hazard on the 16-byte line: outstanding write or one accepted this cycle.
  assign w_raw_block =
      ((r_wr_state != W_IDLE) && (r_wr_addr[ADDR_WIDTH-1:4] == rd_addr[ADDR_WIDTH-1:4])) ||
      (wr_req && wr_rdy && (wr_addr[ADDR_WIDTH-1:4] == rd_addr[ADDR_WIDTH-1:4]));
`else
  assign w_raw_block = 1'b0;
`endif

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_state <= R_IDLE;
    else      r_rd_state <= w_rd_next;
  end

  // Latch the read request on acceptance so AR stays stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
      r_rd_type <= '0;
    end else if (rd_req && rd_rdy) begin
      r_rd_addr <= rd_addr;
      r_rd_type <= rd_type;
    end
  end

  // Read FSM next state and outputs; reset gating keeps rd_rdy low while rst is asserted.
  always_comb begin
    w_rd_next = r_rd_state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    case (r_rd_state)
      R_IDLE: begin
        rd_rdy = rst && !w_raw_block;
        if (rd_req && rd_rdy) w_rd_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rd_next = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) begin
          ret_valid = 1'b1;
          ret_last  = 1'b1;
          ret_data  = rdata;
          w_rd_next = R_IDLE;
        end
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_state <= W_IDLE;
    else      r_wr_state <= w_wr_next;
  end

  // Latch the write request on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr  <= '0;
      r_wr_type  <= '0;
      r_wr_wstrb <= '0;
      r_wr_data  <= '0;
    end else if (wr_req && wr_rdy) begin
      r_wr_addr  <= wr_addr;
      r_wr_type  <= wr_type;
      r_wr_wstrb <= wr_wstrb;
      r_wr_data  <= wr_data;
    end
  end

  // Remember which of AW / W has already handshaken; cleared whenever W_REQ is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_next != W_REQ) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_aw_done <= r_aw_done | w_aw_hs;
      r_w_done  <= r_w_done | w_w_hs;
    end
  end

  // Write FSM next state and outputs; AW and W valids drop independently.
  always_comb begin
    w_wr_next = r_wr_state;
    wr_rdy    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    w_aw_hs   = 1'b0;
    w_w_hs    = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        wr_rdy = rst;
        if (wr_req && wr_rdy) w_wr_next = W_REQ;
      end
      W_REQ: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        w_aw_hs = awvalid && awready;
        w_w_hs  = wvalid && wready;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_wr_next = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge with a queue-based scoreboard.
// Expectations follow BRIDGE_RAW_CHECK_EN when the bench is built with it.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [15:0]  wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [127:0] rdata, wdata;
  logic [15:0]  wstrb;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [34:0]  q_ar[$];   // {size, addr}
  logic [34:0]  q_aw[$];   // {size, addr}
  logic [143:0] q_w[$];    // {strb, data}
  logic [127:0] q_ret[$];

  cache_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .ID_WIDTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [2:0] t);
    if (t == 3'b000)      return 3'd0;
    else if (t == 3'b001) return 3'd1;
    else if (t == 3'b010) return 3'd2;
    else                  return 3'd4;
  endfunction

  // Inputs are driven 2 time units after the rising edge, outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input logic [127:0] data,
                         input int unsigned ar_dly, input int unsigned r_dly,
                         output int unsigned waited);
    logic [34:0]  ar_exp;
    logic [127:0] r_exp;
    rd_req = 1'b1; rd_addr = addr; rd_type = typ;
    #1;
    waited = 0;
    while (!rd_rdy && waited < 40) begin
      step(); #1;
      waited++;
    end
    if (!rd_rdy) begin
      chk("rd_accept_timeout", 0, 1);
      rd_req = 1'b0;
      return;
    end
    q_ar.push_back({exp_size(typ), addr});
    step();
    rd_req = 1'b0; rd_addr = ~addr; rd_type = 3'b001;
    #1;
    ar_exp = q_ar.pop_front();
    for (int unsigned i = 0; i < ar_dly; i++) begin
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, ar_exp[31:0]);
      chk("ar_hold_size", arsize, ar_exp[34:32]);
      chk("rd_rdy_busy", rd_rdy, 0);
      step(); #1;
    end
    arready = 1'b1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, ar_exp[31:0]);
    chk("arsize", arsize, ar_exp[34:32]);
    chk("arlen", arlen, 0);
    chk("arburst", arburst, 1);
    chk("arid", arid, 0);
    step();
    arready = 1'b0;
    rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    for (int unsigned i = 0; i < r_dly; i++) begin
      chk("rready_wait", rready, 1);
      chk("ret_valid_wait", ret_valid, 0);
      chk("ret_data_idle", ret_data, 0);
      step(); #1;
    end
    rvalid = 1'b1; rdata = data;
    q_ret.push_back(data);
    #1;
    r_exp = q_ret.pop_front();
    chk("ret_valid", ret_valid, 1);
    chk("ret_last", ret_last, 1);
    chk("ret_data", ret_data, r_exp);
    step();
    rvalid = 1'b0;
    #1;
    chk("ret_valid_after", ret_valid, 0);
    chk("rready_after", rready, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ, input logic [15:0] strb,
                          input logic [127:0] data, input int unsigned aw_dly,
                          input int unsigned w_dly, input int unsigned b_dly);
    logic [34:0]  aw_exp;
    logic [143:0] w_exp;
    int unsigned  last;
    int unsigned  waited;
    wr_req = 1'b1; wr_addr = addr; wr_type = typ; wr_wstrb = strb; wr_data = data;
    #1;
    waited = 0;
    while (!wr_rdy && waited < 40) begin
      step(); #1;
      waited++;
    end
    if (!wr_rdy) begin
      chk("wr_accept_timeout", 0, 1);
      wr_req = 1'b0;
      return;
    end
    q_aw.push_back({exp_size(typ), addr});
    q_w.push_back({strb, data});
    step();
    wr_req = 1'b0; wr_addr = ~addr; wr_wstrb = ~strb; wr_data = ~data;
    aw_exp = q_aw.pop_front();
    w_exp  = q_w.pop_front();
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int unsigned c = 0; c <= last; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      #1;
      chk("awvalid", awvalid, (c <= aw_dly));
      chk("wvalid", wvalid, (c <= w_dly));
      chk("wr_rdy_busy", wr_rdy, 0);
      if (c == aw_dly) begin
        chk("awaddr", awaddr, aw_exp[31:0]);
        chk("awsize", awsize, aw_exp[34:32]);
        chk("awlen", awlen, 0);
        chk("awburst", awburst, 1);
      end
      if (c == w_dly) begin
        chk("wdata", wdata, w_exp[127:0]);
        chk("wstrb", wstrb, w_exp[143:128]);
        chk("wlast", wlast, 1);
      end
      step();
    end
    awready = 1'b0; wready = 1'b0;
    for (int unsigned i = 0; i < b_dly; i++) begin
      #1;
      chk("bready_wait", bready, 1);
      chk("awvalid_in_b", awvalid, 0);
      step();
    end
    bvalid = 1'b1;
    #1;
    chk("bready", bready, 1);
    step();
    bvalid = 1'b0;
    #1;
    chk("wr_rdy_after_b", wr_rdy, 1);
    chk("bready_after", bready, 0);
  endtask

  int unsigned wt, wt2;
  logic [127:0] d;

  initial begin
    rst = 1'b0;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 2'b10; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 2'b11; bvalid = 0;

    // reset state
    step(); step();
    #1;
    chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_wr_rdy", wr_rdy, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    step();
    rst = 1'b1;
    #1;
    chk("rel_rd_rdy", rd_rdy, 1);
    chk("rel_wr_rdy", wr_rdy, 1);
    step();

    // basic word read
    do_read(32'h1C00_0014, 3'b010, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0, 2, wt);
    chk("read_wait", wt, 0);

    // size mapping, including reserved type codes
    for (int unsigned t = 0; t < 8; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do_read(32'h1000_0000 + t * 32'h44, t[2:0], d, 0, t % 2, wt);
    end

    // AR backpressure for 5 cycles
    do_read(32'h2000_0040, 3'b100, 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0, 5, 1, wt);

    // writes: AW two cycles before W, W before AW, same-cycle handshakes
    do_write(32'h1C00_0020, 3'b010, 16'h00F0, 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666, 1, 3, 1);
    do_write(32'h3000_0008, 3'b000, 16'h0100, 128'hA5A5_A5A5_0000_0000_1111_1111_2222_2222, 3, 0, 0);
    do_write(32'h3000_0100, 3'b100, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0, 2);

    // simultaneous read to 0x100 and write to 0x200
    rd_req = 1; rd_addr = 32'h100; rd_type = 3'b100;
    wr_req = 1; wr_addr = 32'h200; wr_type = 3'b100; wr_wstrb = 16'hFFFF;
    wr_data = 128'hCCCC_DDDD_EEEE_FFFF_0000_1111_2222_3333;
    #1;
    chk("sim_rd_rdy", rd_rdy, 1);
    chk("sim_wr_rdy", wr_rdy, 1);
    step();
    rd_req = 0; wr_req = 0;
    arready = 1; awready = 1; wready = 1;
    #1;
    chk("sim_arvalid", arvalid, 1);
    chk("sim_awvalid", awvalid, 1);
    chk("sim_wvalid", wvalid, 1);
    chk("sim_araddr", araddr, 32'h100);
    chk("sim_awaddr", awaddr, 32'h200);
    step();
    arready = 0; awready = 0; wready = 0;
    rvalid = 1; rdata = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE; bvalid = 1;
    q_ret.push_back(128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
    #1;
    chk("sim_bready", bready, 1);
    chk("sim_ret_valid", ret_valid, 1);
    chk("sim_ret_data", ret_data, q_ret.pop_front());
    step();
    rvalid = 0; bvalid = 0;
    #1;
    chk("sim_rd_rdy_after", rd_rdy, 1);
    chk("sim_wr_rdy_after", wr_rdy, 1);
    step();

    // read to 0x308 while a write to 0x300 is outstanding
    fork
      do_write(32'h300, 3'b010, 16'h000F, 128'h1111_0000_2222_0000_3333_0000_4444_0000, 2, 2, 2);
      begin
        step();
        do_read(32'h308, 3'b010, 128'h9999_0000_8888_0000_7777_0000_6666_0000, 0, 1, wt2);
      end
    join
`ifdef BRIDGE_RAW_CHECK_EN
    chk("raw_wait_cycles", wt2, 6);
`else
    chk("raw_wait_cycles", wt2, 0);
`endif
    step();

    // reset pulled in R_R before rvalid
    rd_req = 1; rd_addr = 32'h500; rd_type = 3'b010;
    #1;
    chk("rr_rd_rdy", rd_rdy, 1);
    step();
    rd_req = 0; arready = 1;
    #1;
    chk("rr_arvalid", arvalid, 1);
    step();
    arready = 0;
    #1;
    chk("rr_rready", rready, 1);
    step();
    rst = 1'b0;
    #1;
    chk("rr_rst_rd_rdy", rd_rdy, 0);
    chk("rr_rst_rready", rready, 0);
    chk("rr_rst_wr_rdy", wr_rdy, 0);
    step();
    rst = 1'b1;
    #1;
    chk("rr_rel_rd_rdy", rd_rdy, 1);
    rvalid = 1; rdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    #1;
    chk("rr_ret_valid", ret_valid, 0);
    chk("rr_ret_data", ret_data, 0);
    step();
    #1;
    chk("rr_ret_valid_2", ret_valid, 0);
    rvalid = 0;
    step();

    chk("sb_ret_empty", q_ret.size(), 0);
    chk("sb_ar_empty", q_ar.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
